// File: rtl/trigger_pkg.sv
// Shared types and default parameter values for the threshold trigger.
// Imported by the compare sub-module and the top level.
package trigger_pkg;

    typedef enum logic [1:0] {
        CMP_GT = 2'd0,
        CMP_GE = 2'd1,
        CMP_LT = 2'd2,
        CMP_EQ = 2'd3
    } cmp_mode_t;

    localparam int DEF_RW      = 10;
    localparam int DEF_TW      = 9;
    localparam int DEF_SHIFT   = 1;
    localparam int DEF_HOLDOFF = 3;
    localparam int DEF_CW      = 8;

endpackage

// File: rtl/threshold_cmp.sv
// Purely combinational scale-and-compare.
// The threshold is left-shifted into an RW-bit word and compared unsigned against rnd.
module threshold_cmp
    import trigger_pkg::*;
#(
    parameter int RW    = DEF_RW,
    parameter int TW    = DEF_TW,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic [TW-1:0] thresh,
    input  logic [RW-1:0] rnd,
    input  logic [1:0]    mode,
    output logic          result
);

    logic [RW-1:0] adj;
    cmp_mode_t     cmp_mode;

    // Zero-extend before shifting so vacated low bits and spare high bits are 0.
    assign adj      = RW'(thresh) << SHIFT;
    assign cmp_mode = cmp_mode_t'(mode);

    always_comb begin
        result = 1'b0;
        unique case (cmp_mode)
            CMP_GT:  result = (adj >  rnd);
            CMP_GE:  result = (adj >= rnd);
            CMP_LT:  result = (adj <  rnd);
            CMP_EQ:  result = (adj == rnd);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/lfsr_threshold_trigger.sv
// Registered threshold trigger between the LFSR and the player/press logic:
// level output, rate-limited one-cycle pulse with hold-off, saturating hit counter.
module lfsr_threshold_trigger
    import trigger_pkg::*;
#(
    parameter int RW      = DEF_RW,
    parameter int TW      = DEF_TW,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int HOLDOFF = DEF_HOLDOFF,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic [TW-1:0] thresh,
    input  logic [RW-1:0] rnd,
    input  logic          rnd_valid,
    output logic          hit_level,
    output logic          hit_pulse,
    output logic          holding,
    output logic [CW-1:0] hit_count
);

    // A zero-width counter is illegal, so HOLDOFF = 0 keeps one bit that never leaves 0.
    localparam int CNTW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hold_state_t;

    if (TW + SHIFT > RW) begin : g_width_check
        $error("lfsr_threshold_trigger: TW+SHIFT must not exceed RW");
    end

    logic            cmp_result;
    logic            accept;
    hold_state_t     state;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic            level_nxt;
    logic            pulse_nxt;
    logic [CW-1:0]   count_nxt;

    threshold_cmp #(
        .RW    (RW),
        .TW    (TW),
        .SHIFT (SHIFT)
    ) u_cmp (
        .thresh (thresh),
        .rnd    (rnd),
        .mode   (mode),
        .result (cmp_result)
    );

    assign accept  = enable && rnd_valid;
    assign holding = (cnt != '0);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state     = (cnt == '0) ? ST_IDLE : ST_HOLD;
        cnt_nxt   = cnt;
        level_nxt = hit_level;
        pulse_nxt = 1'b0;
        count_nxt = hit_count;

        if (accept) begin
            level_nxt = cmp_result;
        end

        unique case (state)
            ST_IDLE: begin
                if (accept && cmp_result) begin
                    pulse_nxt = 1'b1;
                    cnt_nxt   = CNTW'(HOLDOFF);
                    if (hit_count != '1) begin
                        count_nxt = hit_count + CW'(1);
                    end
                end
            end
            // The edge that takes cnt from 1 to 0 is still a HOLD edge and cannot fire.
            ST_HOLD: cnt_nxt = cnt - CNTW'(1);
            default: cnt_nxt = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            hit_level <= 1'b0;
            hit_pulse <= 1'b0;
            hit_count <= '0;
        end else begin
            cnt       <= cnt_nxt;
            hit_level <= level_nxt;
            hit_pulse <= pulse_nxt;
            hit_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_lfsr_threshold_trigger.sv
// Directed self-checking bench for lfsr_threshold_trigger (default instance plus a
// CW=4, HOLDOFF=0 instance for saturation).
module tb_lfsr_threshold_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [8:0] thresh;
    logic [9:0] rnd;
    logic       rnd_valid;

    logic       hit_level, hit_pulse, holding;
    logic [7:0] hit_count;
    logic       s_level, s_pulse, s_holding;
    logic [3:0] s_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_threshold_trigger dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .thresh(thresh),
        .rnd(rnd), .rnd_valid(rnd_valid), .hit_level(hit_level), .hit_pulse(hit_pulse),
        .holding(holding), .hit_count(hit_count)
    );

    lfsr_threshold_trigger #(.CW(4), .HOLDOFF(0)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .thresh(thresh),
        .rnd(rnd), .rnd_valid(rnd_valid), .hit_level(s_level), .hit_pulse(s_pulse),
        .holding(s_holding), .hit_count(s_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic sample(input logic [1:0] m, input logic [8:0] t, input logic [9:0] r);
        mode = m; thresh = t; rnd = r; rnd_valid = 1'b1; enable = 1'b1;
        step();
        rnd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'd0; thresh = '0; rnd = '0; rnd_valid = 1'b0;
        step();
        step();
        check("rst_level", hit_level, 0);
        check("rst_pulse", hit_pulse, 0);
        check("rst_holding", holding, 0);
        check("rst_count", hit_count, 0);
        reset = 1'b0;

        // Basic GT: adj=234 > 200.
        sample(2'd0, 9'd117, 10'd200);
        check("gt_level", hit_level, 1);
        check("gt_pulse", hit_pulse, 1);
        check("gt_count", hit_count, 1);
        check("gt_holding", holding, 1);
        step();
        check("gt_pulse_one_cycle", hit_pulse, 0);
        check("gt_level_held", hit_level, 1);
        sample(2'd0, 9'd117, 10'd500);
        check("gt_500_level", hit_level, 0);
        check("gt_500_pulse", hit_pulse, 0);
        repeat (3) step();

        // Modes at equality rnd == adj == 234.
        sample(2'd0, 9'd117, 10'd234); check("eq_gt", hit_level, 0);
        sample(2'd1, 9'd117, 10'd234); check("eq_ge", hit_level, 1);
        sample(2'd3, 9'd117, 10'd234); check("eq_eq", hit_level, 1);
        sample(2'd2, 9'd117, 10'd234); check("eq_lt", hit_level, 0);
        sample(2'd2, 9'd117, 10'd235); check("lt_235", hit_level, 1);
        sample(2'd2, 9'd117, 10'd233); check("lt_233", hit_level, 0);

        // Hold-off: true sample every edge for 12 edges.
        do_reset();
        mode = 2'd0; thresh = 9'd117; rnd = 10'd0; enable = 1'b1; rnd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("hold_pulse_%0d", i), hit_pulse, (i % 4 == 0) ? 1 : 0);
            check($sformatf("hold_holding_%0d", i), holding, (i % 4 != 3) ? 1 : 0);
        end
        check("hold_count", hit_count, 3);
        rnd_valid = 1'b0;

        // Gating: clear the level, then offer true samples with enable or valid low.
        sample(2'd0, 9'd117, 10'd500);
        check("gate_level_clear", hit_level, 0);
        enable = 1'b0; rnd_valid = 1'b1; rnd = 10'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("gate_en_pulse_%0d", i), hit_pulse, 0);
            check($sformatf("gate_en_level_%0d", i), hit_level, 0);
        end
        enable = 1'b1; rnd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("gate_val_pulse_%0d", i), hit_pulse, 0);
            check($sformatf("gate_val_level_%0d", i), hit_level, 0);
        end
        check("gate_count", hit_count, 3);

        // Hold-off continues counting down with enable low.
        sample(2'd0, 9'd117, 10'd0);
        check("hold_en_pulse", hit_pulse, 1);
        check("hold_en_count", hit_count, 4);
        enable = 1'b0; rnd_valid = 1'b1;
        step(); check("hold_en_h1", holding, 1);
        step(); check("hold_en_h2", holding, 1);
        step(); check("hold_en_h3", holding, 0);
        rnd_valid = 1'b0;

        // Boundaries: adj=0 never GT; thresh all ones gives adj=1022.
        sample(2'd0, 9'd0, 10'd0);     check("adj0_gt", hit_level, 0);
        sample(2'd3, 9'd511, 10'd1023); check("ones_eq_1023", hit_level, 0);
        sample(2'd3, 9'd511, 10'd1022); check("ones_eq_1022", hit_level, 1);
        check("ones_eq_pulse", hit_pulse, 1);
        check("ones_eq_count", hit_count, 5);
        repeat (3) step();

        // Reset mid-HOLD overrides a concurrent true sample.
        sample(2'd0, 9'd117, 10'd0);
        check("mid_pulse", hit_pulse, 1);
        rnd_valid = 1'b1; enable = 1'b1; reset = 1'b1;
        step();
        check("mid_rst_level", hit_level, 0);
        check("mid_rst_pulse", hit_pulse, 0);
        check("mid_rst_holding", holding, 0);
        check("mid_rst_count", hit_count, 0);
        reset = 1'b0;
        sample(2'd0, 9'd117, 10'd0);
        check("post_rst_pulse", hit_pulse, 1);
        check("post_rst_count", hit_count, 1);

        // Saturation on the CW=4, HOLDOFF=0 instance.
        do_reset();
        check("sat_rst_count", s_count, 0);
        mode = 2'd0; thresh = 9'd117; rnd = 10'd0; enable = 1'b1; rnd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("sat_pulse_%0d", i), s_pulse, 1);
            check($sformatf("sat_count_%0d", i), s_count, (i + 1 > 15) ? 15 : i + 1);
            check($sformatf("sat_holding_%0d", i), s_holding, 0);
        end
        rnd_valid = 1'b0;
        step();
        check("sat_pulse_stop", s_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
